// File: rtl/pc_pkg.sv
// Shared constants for the program-counter unit: next-PC source encodings
// and the default exception vector.
package pc_pkg;

    localparam logic [2:0] SEL_SEQ = 3'd0;
    localparam logic [2:0] SEL_BR  = 3'd1;
    localparam logic [2:0] SEL_J   = 3'd2;
    localparam logic [2:0] SEL_JR  = 3'd3;
    localparam logic [2:0] SEL_RET = 3'd4;
    localparam logic [2:0] SEL_EXC = 3'd5;

    localparam logic [31:0] DEFAULT_EXC_VEC = 32'h0000_0080;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// replace rewrites the top in place without moving the pointer.
module ras_stack #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              push,
    input  logic              pop,
    input  logic              replace,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] entries [RAS_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  top_ptr;

    // The pointer addresses the next free slot, so the top lives one below it.
    assign top_ptr = wr_ptr - 1'b1;
    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign top     = empty ? '0 : entries[top_ptr];

    always_ff @(posedge clk) begin
        if (Reset) begin
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (replace) begin
            entries[top_ptr] <= push_data;
        end else if (push) begin
            entries[wr_ptr] <= push_data;
            wr_ptr          <= wr_ptr + 1'b1;
            if (!full) begin
                count <= count + 1'b1;
            end
        end else if (pop && !empty) begin
            wr_ptr <= wr_ptr - 1'b1;
            count  <= count - 1'b1;
        end
    end

endmodule

// File: rtl/pc_ras_unit.sv
// Program-counter register with six next-address sources, a return-address
// stack for call/return pairs and a registered misaligned-target flag.
module pc_ras_unit
    import pc_pkg::*;
#(
    parameter int               ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [31:0]      EXC_VEC   = DEFAULT_EXC_VEC,
    parameter int               RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              PCWre,
    input  logic [2:0]        pc_sel,
    input  logic              link,
    input  logic [15:0]       br_offset,
    input  logic [25:0]       j_index,
    input  logic [ADDR_W-1:0] jr_target,
    output logic [ADDR_W-1:0] currentIAddr,
    output logic [ADDR_W-1:0] ras_top,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              misalign_err
);

    localparam logic [ADDR_W-1:0] EXC_ADDR = ADDR_W'(EXC_VEC);

    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] j_target;
    logic [ADDR_W-1:0] reg_target;
    logic [ADDR_W-1:0] next_pc;
    logic              is_reg_jump;
    logic              misaligned;
    logic              push_req;
    logic              pop_req;
    logic              do_replace;

    assign pc4       = currentIAddr + ADDR_W'(4);
    assign br_target = pc4 + {{(ADDR_W-18){br_offset[15]}}, br_offset, 2'b00};

    // Jump keeps the region bits of pc4 above bit 27.
    always_comb begin
        j_target       = pc4;
        j_target[27:0] = {j_index, 2'b00};
    end

    assign is_reg_jump = (pc_sel == SEL_JR) || (pc_sel == SEL_RET);
    assign reg_target  = ((pc_sel == SEL_RET) && !ras_empty) ? ras_top : jr_target;
    assign misaligned  = is_reg_jump && (reg_target[1:0] != 2'b00);

    always_comb begin
        next_pc = pc4;
        case (pc_sel)
            SEL_BR:  next_pc = br_target;
            SEL_J:   next_pc = j_target;
            SEL_JR:  next_pc = reg_target;
            SEL_RET: next_pc = reg_target;
            SEL_EXC: next_pc = EXC_ADDR;
            default: next_pc = pc4;
        endcase
        if (misaligned) begin
            next_pc = EXC_ADDR;
        end
    end

    // Call+return in one update rewrites the top; on an empty stack it is a push.
    assign push_req   = PCWre && link;
    assign pop_req    = PCWre && (pc_sel == SEL_RET);
    assign do_replace = push_req && pop_req && !ras_empty;

    ras_stack #(
        .ADDR_W   (ADDR_W),
        .RAS_DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .Reset    (Reset),
        .push     (push_req && !do_replace),
        .pop      (pop_req && !do_replace),
        .replace  (do_replace),
        .push_data(pc4),
        .top      (ras_top),
        .empty    (ras_empty),
        .full     (ras_full)
    );

    always_ff @(posedge clk) begin
        if (Reset) begin
            currentIAddr <= RESET_VEC;
            misalign_err <= 1'b0;
        end else if (PCWre) begin
            currentIAddr <= next_pc;
            misalign_err <= misaligned;
        end else begin
            misalign_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed bench for pc_ras_unit: one task per scenario, hand-computed
// expectations checked inline after each clock edge.
module tb_pc_ras_unit;
    import pc_pkg::*;

    logic        clk;
    logic        Reset;
    logic        PCWre;
    logic [2:0]  pc_sel;
    logic        link;
    logic [15:0] br_offset;
    logic [25:0] j_index;
    logic [31:0] jr_target;
    logic [31:0] currentIAddr;
    logic [31:0] ras_top;
    logic        ras_empty;
    logic        ras_full;
    logic        misalign_err;

    int errors = 0;
    int checks = 0;

    pc_ras_unit #(
        .ADDR_W   (32),
        .RESET_VEC(32'h0),
        .EXC_VEC  (32'h0000_0080),
        .RAS_DEPTH(4)
    ) dut (
        .clk         (clk),
        .Reset       (Reset),
        .PCWre       (PCWre),
        .pc_sel      (pc_sel),
        .link        (link),
        .br_offset   (br_offset),
        .j_index     (j_index),
        .jr_target   (jr_target),
        .currentIAddr(currentIAddr),
        .ras_top     (ras_top),
        .ras_empty   (ras_empty),
        .ras_full    (ras_full),
        .misalign_err(misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one update's inputs, clock it, and settle 1 time unit past the edge.
    task automatic cycle(input logic rst, input logic we, input logic [2:0] sel,
                         input logic lnk, input logic [15:0] off,
                         input logic [25:0] idx, input logic [31:0] jr);
        Reset     = rst;
        PCWre     = we;
        pc_sel    = sel;
        link      = lnk;
        br_offset = off;
        j_index   = idx;
        jr_target = jr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pc(input string name, input logic [31:0] exp);
        checks++;
        if (currentIAddr !== exp) begin
            errors++;
            $display("FAIL %s: currentIAddr=%h expected=%h", name, currentIAddr, exp);
        end
    endtask

    task automatic test_reset();
        cycle(1, 1, SEL_SEQ, 0, 16'h0, 26'h0, 32'h0);
        cycle(1, 1, SEL_SEQ, 0, 16'h0, 26'h0, 32'h0);
        chk_pc("reset_pc", 32'h0);
        checks++;
        if ({ras_empty, ras_full, misalign_err} !== 3'b100 || ras_top !== 32'h0) begin
            errors++;
            $display("FAIL reset_flags: empty/full/mis=%b top=%h expected=100 top=0",
                     {ras_empty, ras_full, misalign_err}, ras_top);
        end
        cycle(0, 1, SEL_SEQ, 0, 16'h0, 26'h0, 32'h0);
        chk_pc("seq_1", 32'h4);
        cycle(0, 1, SEL_SEQ, 0, 16'h0, 26'h0, 32'h0);
        chk_pc("seq_2", 32'h8);
        cycle(0, 1, SEL_SEQ, 0, 16'h0, 26'h0, 32'h0);
        chk_pc("seq_3", 32'hC);
        // Hold with link asserted: nothing may change, including the stack.
        cycle(0, 0, SEL_BR, 1, 16'h0010, 26'h0, 32'h0);
        chk_pc("hold", 32'hC);
        checks++;
        if (ras_empty !== 1'b1) begin
            errors++;
            $display("FAIL hold_link_ignored: ras_empty=%b expected=1", ras_empty);
        end
    endtask

    task automatic test_branch_jump();
        cycle(0, 1, SEL_JR, 0, 16'h0, 26'h0, 32'h100);
        chk_pc("jr_0x100", 32'h100);
        cycle(0, 1, SEL_BR, 0, 16'hFFFE, 26'h0, 32'h0);
        chk_pc("br_neg", 32'hFC);
        cycle(0, 1, SEL_J, 0, 16'h0, 26'h40, 32'h0);
        chk_pc("j_0x40", 32'h100);
        cycle(0, 1, 3'd7, 0, 16'h0, 26'h0, 32'h0);
        chk_pc("unused_sel", 32'h104);
        cycle(0, 1, SEL_EXC, 0, 16'h0, 26'h0, 32'h0);
        chk_pc("exc", 32'h80);
        // Region bits above 27 come from pc4.
        cycle(0, 1, SEL_JR, 0, 16'h0, 26'h0, 32'hF000_0010);
        cycle(0, 1, SEL_J, 0, 16'h0, 26'h3FF_FFFF, 32'h0);
        chk_pc("j_region", 32'hFFFF_FFFC);
        cycle(0, 1, SEL_SEQ, 0, 16'h0, 26'h0, 32'h0);
        chk_pc("seq_wrap", 32'h0);
    endtask

    task automatic test_call_return();
        cycle(0, 1, SEL_JR, 0, 16'h0, 26'h0, 32'h200);
        cycle(0, 1, SEL_J, 1, 16'h0, 26'h80, 32'h0);
        chk_pc("call_pc", 32'h200);
        checks++;
        if (ras_top !== 32'h204 || ras_empty !== 1'b0) begin
            errors++;
            $display("FAIL call_top: ras_top=%h empty=%b expected=00000204 empty=0",
                     ras_top, ras_empty);
        end
        cycle(0, 1, SEL_SEQ, 0, 16'h0, 26'h0, 32'h0);
        cycle(0, 1, SEL_RET, 0, 16'h0, 26'h0, 32'h500);
        chk_pc("ret_pc", 32'h204);
        checks++;
        if (ras_empty !== 1'b1 || ras_top !== 32'h0) begin
            errors++;
            $display("FAIL ret_empty: ras_empty=%b top=%h expected=1 top=0", ras_empty, ras_top);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_ret [4];
        exp_ret[0] = 32'h1014;
        exp_ret[1] = 32'h1010;
        exp_ret[2] = 32'h100C;
        exp_ret[3] = 32'h1008;
        cycle(0, 1, SEL_JR, 0, 16'h0, 26'h0, 32'h1000);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, SEL_SEQ, 1, 16'h0, 26'h0, 32'h0);
        end
        chk_pc("ovf_pc", 32'h1014);
        checks++;
        if (ras_full !== 1'b1 || ras_top !== 32'h1014) begin
            errors++;
            $display("FAIL ovf_full: ras_full=%b top=%h expected=1 top=00001014", ras_full, ras_top);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, SEL_RET, 0, 16'h0, 26'h0, 32'h300);
            chk_pc($sformatf("ovf_ret_%0d", i), exp_ret[i]);
        end
        checks++;
        if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drained: empty=%b full=%b expected=1 0", ras_empty, ras_full);
        end
        cycle(0, 1, SEL_RET, 0, 16'h0, 26'h0, 32'h300);
        chk_pc("ret_fallback", 32'h300);
    endtask

    task automatic test_misalign();
        cycle(0, 1, SEL_JR, 0, 16'h0, 26'h0, 32'h102);
        chk_pc("misalign_pc", 32'h80);
        checks++;
        if (misalign_err !== 1'b1) begin
            errors++;
            $display("FAIL misalign_pulse: misalign_err=%b expected=1", misalign_err);
        end
        cycle(0, 1, SEL_SEQ, 0, 16'h0, 26'h0, 32'h0);
        chk_pc("misalign_next", 32'h84);
        checks++;
        if (misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL misalign_clear: misalign_err=%b expected=0", misalign_err);
        end
        cycle(0, 1, SEL_RET, 0, 16'h0, 26'h0, 32'h301);
        chk_pc("ret_misalign_pc", 32'h80);
        checks++;
        if (misalign_err !== 1'b1) begin
            errors++;
            $display("FAIL ret_misalign_pulse: misalign_err=%b expected=1", misalign_err);
        end
        cycle(0, 0, SEL_JR, 0, 16'h0, 26'h0, 32'h103);
        checks++;
        if (misalign_err !== 1'b0 || currentIAddr !== 32'h80) begin
            errors++;
            $display("FAIL misalign_hold: misalign_err=%b pc=%h expected=0 pc=00000080",
                     misalign_err, currentIAddr);
        end
    endtask

    task automatic test_simultaneous_reset();
        cycle(0, 1, SEL_JR, 0, 16'h0, 26'h0, 32'h200);
        cycle(0, 1, SEL_J, 1, 16'h0, 26'h80, 32'h0);
        cycle(0, 1, SEL_JR, 0, 16'h0, 26'h0, 32'h400);
        cycle(0, 1, SEL_RET, 1, 16'h0, 26'h0, 32'h0);
        chk_pc("sim_pc", 32'h204);
        checks++;
        if (ras_top !== 32'h404 || ras_empty !== 1'b0 || ras_full !== 1'b0) begin
            errors++;
            $display("FAIL sim_top: ras_top=%h empty=%b full=%b expected=00000404 0 0",
                     ras_top, ras_empty, ras_full);
        end
        // Count unchanged at one: a single pop empties the stack.
        cycle(0, 1, SEL_RET, 0, 16'h0, 26'h0, 32'h0);
        chk_pc("sim_pop", 32'h404);
        checks++;
        if (ras_empty !== 1'b1) begin
            errors++;
            $display("FAIL sim_count: ras_empty=%b expected=1", ras_empty);
        end
        cycle(0, 1, SEL_SEQ, 1, 16'h0, 26'h0, 32'h0);
        cycle(1, 1, SEL_SEQ, 1, 16'h0, 26'h0, 32'h0);
        chk_pc("mid_reset_pc", 32'h0);
        checks++;
        if (ras_empty !== 1'b1 || ras_top !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_ras: empty=%b top=%h expected=1 top=0", ras_empty, ras_top);
        end
        cycle(0, 1, SEL_RET, 0, 16'h0, 26'h0, 32'h500);
        chk_pc("post_reset_ret", 32'h500);
    endtask

    initial begin
        Reset     = 1'b1;
        PCWre     = 1'b0;
        pc_sel    = SEL_SEQ;
        link      = 1'b0;
        br_offset = '0;
        j_index   = '0;
        jr_target = '0;
        test_reset();
        test_branch_jump();
        test_call_return();
        test_overflow();
        test_misalign();
        test_simultaneous_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_ras_unit.md
# pc_ras_unit

Parametrised program-counter unit for the multicycle MIPS core. It holds the current instruction address and computes the next address from six selectable sources: sequential, branch, jump, register jump, return-address-stack pop and exception vector. It also keeps a circular return-address stack (RAS) for call/return pairs and flags misaligned register targets. It sits between the control unit and instruction memory and supersedes the plain PC register.

## Interface
Parameters:
- ADDR_W, 32: address width; minimum 28.
- RESET_VEC, 0: value loaded into currentIAddr on reset.
- EXC_VEC, 32'h0000_0080: exception handler address, truncated to ADDR_W.
- RAS_DEPTH, 4: number of RAS entries; power of two, 2 to 16.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  reset, synchronous, active-high.
- PCWre  in  1  update enable; when 0, all state holds.
- pc_sel  in  3  next-PC source, encoded SEL_SEQ/SEL_BR/SEL_J/SEL_JR/SEL_RET/SEL_EXC.
- link  in  1  call: push return address currentIAddr+4 on an update.
- br_offset  in  16  signed word offset for branches.
- j_index  in  26  jump instruction index.
- jr_target  in  ADDR_W  register target for JR, and fallback for RET.
- currentIAddr  out  ADDR_W  current instruction address.
- ras_top  out  ADDR_W  top RAS entry; 0 when empty.
- ras_empty  out  1  RAS count == 0.
- ras_full  out  1  RAS count == RAS_DEPTH.
- misalign_err  out  1  one-cycle pulse: JR/RET target had nonzero bits [1:0].

## Operation
Definitions:
- pc4 = currentIAddr + 4, width ADDR_W, wraps modulo 2^ADDR_W.

Next-PC selection, applied only when PCWre=1:
- SEL_SEQ: pc4.
- SEL_BR: pc4 + (sign-extend(br_offset) << 2), modulo 2^ADDR_W.
- SEL_J: {pc4[ADDR_W-1:28], j_index, 2'b00}.
- SEL_JR: jr_target.
- SEL_RET: ras_top if the RAS is not empty, otherwise jr_target.
- SEL_EXC: EXC_VEC.
- Unused encodings behave as SEL_SEQ.

Misalignment:
- Applies to SEL_JR and SEL_RET when the selected target has bits [1:0] != 0.
- PC loads EXC_VEC instead and misalign_err=1 for that cycle.
- A RAS pop still occurs.

RAS push (link=1):
- Writes pc4 at the write pointer and advances the pointer.
- count increments and saturates at RAS_DEPTH.
- When full, the oldest entry is overwritten (circular).

RAS pop (SEL_RET, RAS not empty):
- Retreats the pointer and decrements count.
- When empty, nothing is popped and the jr_target fallback is used.

Simultaneous link=1 and SEL_RET:
- Top entry is replaced in place with pc4; pointer and count are unchanged.
- If the RAS is empty, this acts as a plain push.

Other rules:
- link is ignored when PCWre=0.
- PCWre=0: PC, RAS and pointers all hold, and misalign_err=0.

## Timing
- Reset=1 at an edge:
  - currentIAddr=RESET_VEC.
  - RAS pointer=0, count=0, all entries=0.
  - ras_empty=1, ras_full=0, misalign_err=0, ras_top=0.
- Reset has priority over PCWre.
- Reset asserted mid-sequence discards all RAS contents in that cycle.
- Update latency is one cycle: inputs sampled at edge N appear on currentIAddr after edge N.
- ras_top, ras_empty and ras_full are combinational from registered state and reflect the post-edge state.
- misalign_err is registered, high for exactly the cycle following the offending update.
- No handshake: the control unit holds PCWre high only for the intended update cycle.

## Structure
- Shared package pc_pkg holds:
  - the pc_sel localparams (SEL_SEQ=0, SEL_BR=1, SEL_J=2, SEL_JR=3, SEL_RET=4, SEL_EXC=5);
  - the default EXC_VEC constant.
- One sub-module is natural: ras_stack (parametrised by ADDR_W and RAS_DEPTH), with push/pop/replace inputs and top/empty/full outputs.
- Next-PC mux and misalignment check stay in pc_ras_unit.

## Test plan
- Reset: Reset=1 for 2 cycles with PCWre=1, RESET_VEC=0 -> currentIAddr=0, ras_empty=1. Then 3 cycles of SEL_SEQ -> 4, 8, 12. Then 1 cycle with PCWre=0 -> holds at 12.
- Branch/jump: at PC=0x100, SEL_BR with br_offset=16'hFFFE -> 0xFC. Then SEL_J with j_index=0x40 -> 0x100.
- Call/return: at PC=0x200, SEL_J with link=1 -> ras_top=0x204. A later SEL_RET -> PC=0x204, ras_empty=1.
- Overflow: 5 consecutive link pushes with RAS_DEPTH=4 -> ras_full=1, oldest entry lost. Then 4 SEL_RET -> the four newest return addresses in LIFO order. A 5th SEL_RET with jr_target=0x300 -> PC=0x300.
- Misalignment: SEL_JR with jr_target=0x102 -> PC=EXC_VEC, misalign_err high for exactly one cycle.
- Simultaneous and reset: SEL_RET with link=1 at PC=0x400 and ras_top=0x204 -> PC=0x204, ras_top=0x404, count unchanged. Then Reset=1 -> RAS empty, PC=RESET_VEC.
